// File: rtl/cwe1234_lock_bank.sv
// Bank of NUM_CH write-protected registers with sticky per-channel locks.
// Locks can only be bypassed through an authenticated, time-limited debug mode
// that permanently locks out after too many wrong keys.
module cwe1234_lock_bank #(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       CH_W        = 2,
  parameter logic [WIDTH-1:0]  DBG_KEY     = 16'hA5C3,
  parameter int unsigned       MAX_FAILS   = 3,
  parameter int unsigned       DBG_TIMEOUT = 255
) (
  input  logic                    Clk,
  input  logic                    resetn,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    resp_valid,
  output logic                    resp_err,
  input  logic [NUM_CH-1:0]       lock_req,
  input  logic                    dbg_req,
  input  logic [WIDTH-1:0]        dbg_key,
  input  logic                    dbg_exit,
  output logic [NUM_CH*WIDTH-1:0] Data_out,
  output logic [NUM_CH-1:0]       lock_status,
  output logic                    dbg_active,
  output logic                    dbg_lockout
);

  localparam int unsigned FAIL_W = ($clog2(MAX_FAILS + 1) < 1) ? 1 : $clog2(MAX_FAILS + 1);
  localparam int unsigned TMO_W  = ($clog2(DBG_TIMEOUT) < 1) ? 1 : $clog2(DBG_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_LOCKOUT = 2'd2
  } dbg_state_e;

  logic [NUM_CH*WIDTH-1:0] data_q, data_d;
  logic [NUM_CH-1:0]       lock_q, lock_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  dbg_state_e              state_q, state_d;
  logic [FAIL_W-1:0]       fail_q, fail_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    dbg_active_q, dbg_active_d;
  logic                    dbg_lockout_q, dbg_lockout_d;
  logic                    accept;
  logic                    permitted;

  // Write path: permission check, register update, locks and response
  always_comb begin
    data_d       = data_q;
    permitted    = 1'b0;
    accept       = wr_valid & wr_ready_q;
    lock_d       = lock_q | lock_req;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (wr_ch == CH_W'(i)) begin
        // a same-cycle lock request already blocks the write
        permitted = (~lock_q[i] & ~lock_req[i]) | dbg_active_q;
        if (accept && permitted) begin
          data_d[i*WIDTH +: WIDTH] = wr_data;
        end
      end
    end
    wr_ready_d   = ~accept;
    resp_valid_d = accept;
    resp_err_d   = accept & ~permitted;
  end

  // Debug unlock FSM: key check, fail counting, timeout
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (dbg_req) begin
          if (dbg_key == DBG_KEY) begin
            state_d = ST_ACTIVE;
            fail_d  = '0;
            tmo_d   = '0;
          end else if (fail_q != FAIL_W'(MAX_FAILS)) begin
            fail_d = fail_q + FAIL_W'(1);
            if (fail_d == FAIL_W'(MAX_FAILS)) begin
              state_d = ST_LOCKOUT;
            end
          end
        end
      end
      ST_ACTIVE: begin
        if (dbg_exit || (tmo_q == TMO_W'(DBG_TIMEOUT - 1))) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_LOCKOUT: state_d = ST_LOCKOUT;
      default:    state_d = ST_IDLE;
    endcase
    dbg_active_d  = (state_d == ST_ACTIVE);
    dbg_lockout_d = (state_d == ST_LOCKOUT);
  end

  // State registers; reset clears everything including in-flight responses
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      data_q        <= '0;
      lock_q        <= '0;
      wr_ready_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      state_q       <= ST_IDLE;
      fail_q        <= '0;
      tmo_q         <= '0;
      dbg_active_q  <= 1'b0;
      dbg_lockout_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      lock_q        <= lock_d;
      wr_ready_q    <= wr_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      state_q       <= state_d;
      fail_q        <= fail_d;
      tmo_q         <= tmo_d;
      dbg_active_q  <= dbg_active_d;
      dbg_lockout_q <= dbg_lockout_d;
    end
  end

  assign Data_out    = data_q;
  assign lock_status = lock_q;
  assign wr_ready    = wr_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign dbg_active  = dbg_active_q;
  assign dbg_lockout = dbg_lockout_q;

endmodule

// File: tb/tb_cwe1234_lock_bank.sv
// Directed bench for cwe1234_lock_bank: 3 channels so an out-of-range index
// exists, short debug timeout so the forced exit is observable.
module tb_cwe1234_lock_bank;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CH_W   = 2;

  logic                    Clk;
  logic                    resetn;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [CH_W-1:0]         wr_ch;
  logic [WIDTH-1:0]        wr_data;
  logic                    resp_valid;
  logic                    resp_err;
  logic [NUM_CH-1:0]       lock_req;
  logic                    dbg_req;
  logic [WIDTH-1:0]        dbg_key;
  logic                    dbg_exit;
  logic [NUM_CH*WIDTH-1:0] Data_out;
  logic [NUM_CH-1:0]       lock_status;
  logic                    dbg_active;
  logic                    dbg_lockout;

  int checks = 0;
  int errors = 0;

  cwe1234_lock_bank #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .CH_W(CH_W), .DBG_KEY(16'hA5C3),
    .MAX_FAILS(3), .DBG_TIMEOUT(8)
  ) dut (
    .Clk(Clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_data(wr_data), .resp_valid(resp_valid), .resp_err(resp_err),
    .lock_req(lock_req), .dbg_req(dbg_req), .dbg_key(dbg_key), .dbg_exit(dbg_exit),
    .Data_out(Data_out), .lock_status(lock_status), .dbg_active(dbg_active),
    .dbg_lockout(dbg_lockout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one write (optionally with a same-cycle lock request); returns the response seen
  task automatic do_write(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] data,
                          input logic [NUM_CH-1:0] lk, output logic rv, output logic re);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_wait: wr_ready=%b after %0d cycles, required 1", wr_ready, n);
    end
    wr_valid = 1'b1; wr_ch = ch; wr_data = data; lock_req = lk;
    @(negedge Clk);
    wr_valid = 1'b0; lock_req = '0;
    rv = resp_valid;
    re = resp_err;
  endtask

  task automatic test_reset();
    resetn = 1'b0; wr_valid = 0; wr_ch = 0; wr_data = 0; lock_req = 0;
    dbg_req = 0; dbg_key = 0; dbg_exit = 0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Data_out, lock_status, wr_ready, resp_valid, resp_err, dbg_active, dbg_lockout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h lock=%b rdy=%b rv=%b re=%b act=%b lo=%b, required all 0",
               Data_out, lock_status, wr_ready, resp_valid, resp_err, dbg_active, dbg_lockout);
    end
    resetn = 1'b1;
    @(negedge Clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: wr_ready=%b, required 1", wr_ready);
    end
  endtask

  task automatic test_write();
    logic rv, re;
    do_write(2'd2, 16'h1234, '0, rv, re);
    checks++;
    if (rv !== 1'b1 || re !== 1'b0) begin
      errors++;
      $display("FAIL write_ch2_resp: rv=%b re=%b, required rv=1 re=0", rv, re);
    end
    checks++;
    if (Data_out[2*WIDTH +: WIDTH] !== 16'h1234) begin
      errors++;
      $display("FAIL write_ch2_data: ch2=%h, required 1234", Data_out[2*WIDTH +: WIDTH]);
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_resp: wr_ready=%b, required 0", wr_ready);
    end
    @(negedge Clk);
    checks++;
    if (resp_valid !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_pulse: rv=%b rdy=%b, required rv=0 rdy=1", resp_valid, wr_ready);
    end
  endtask

  task automatic test_lock();
    logic rv, re;
    lock_req = 3'b010;
    @(negedge Clk);
    lock_req = '0;
    checks++;
    if (lock_status !== 3'b010) begin
      errors++;
      $display("FAIL lock_set: lock_status=%b, required 010", lock_status);
    end
    do_write(2'd1, 16'hBEEF, '0, rv, re);
    checks++;
    if (rv !== 1'b1 || re !== 1'b1 || Data_out[1*WIDTH +: WIDTH] !== 16'h0000) begin
      errors++;
      $display("FAIL locked_write: rv=%b re=%b ch1=%h, required rv=1 re=1 ch1=0000",
               rv, re, Data_out[1*WIDTH +: WIDTH]);
    end
    do_write(2'd0, 16'h5555, 3'b001, rv, re);
    checks++;
    if (re !== 1'b1 || Data_out[0 +: WIDTH] !== 16'h0000 || lock_status !== 3'b011) begin
      errors++;
      $display("FAIL same_cycle_lock: re=%b ch0=%h lock=%b, required re=1 ch0=0000 lock=011",
               re, Data_out[0 +: WIDTH], lock_status);
    end
  endtask

  task automatic test_debug();
    logic rv, re;
    dbg_req = 1'b1; dbg_key = 16'hA5C3;
    @(negedge Clk);
    dbg_req = 1'b0; dbg_key = '0;
    checks++;
    if (dbg_active !== 1'b1) begin
      errors++;
      $display("FAIL dbg_unlock: dbg_active=%b, required 1", dbg_active);
    end
    do_write(2'd1, 16'h00FF, '0, rv, re);
    checks++;
    if (re !== 1'b0 || Data_out[1*WIDTH +: WIDTH] !== 16'h00FF) begin
      errors++;
      $display("FAIL dbg_write: re=%b ch1=%h, required re=0 ch1=00FF", re, Data_out[1*WIDTH +: WIDTH]);
    end
    dbg_exit = 1'b1;
    @(negedge Clk);
    dbg_exit = 1'b0;
    checks++;
    if (dbg_active !== 1'b0) begin
      errors++;
      $display("FAIL dbg_exit: dbg_active=%b, required 0", dbg_active);
    end
    do_write(2'd1, 16'h1111, '0, rv, re);
    checks++;
    if (re !== 1'b1 || Data_out[1*WIDTH +: WIDTH] !== 16'h00FF || lock_status[1] !== 1'b1) begin
      errors++;
      $display("FAIL post_exit_write: re=%b ch1=%h lock1=%b, required re=1 ch1=00FF lock1=1",
               re, Data_out[1*WIDTH +: WIDTH], lock_status[1]);
    end
  endtask

  task automatic test_timeout();
    logic rv, re;
    int n = 0;
    dbg_req = 1'b1; dbg_key = 16'hA5C3;
    @(negedge Clk);
    dbg_req = 1'b0; dbg_key = '0;
    while (dbg_active === 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL dbg_timeout: active lasted %0d cycles, required 8", n);
    end
    do_write(2'd3, 16'hCAFE, '0, rv, re);
    checks++;
    if (rv !== 1'b1 || re !== 1'b1) begin
      errors++;
      $display("FAIL bad_channel: rv=%b re=%b, required rv=1 re=1", rv, re);
    end
  endtask

  task automatic test_lockout();
    for (int k = 0; k < 3; k++) begin
      dbg_req = 1'b1; dbg_key = 16'h0000;
      @(negedge Clk);
      dbg_req = 1'b0;
      checks++;
      if (dbg_lockout !== (k == 2)) begin
        errors++;
        $display("FAIL wrong_key_%0d: dbg_lockout=%b, required %b", k, dbg_lockout, k == 2);
      end
    end
    dbg_req = 1'b1; dbg_key = 16'hA5C3;
    @(negedge Clk);
    dbg_req = 1'b0; dbg_key = '0;
    @(negedge Clk);
    checks++;
    if (dbg_active !== 1'b0 || dbg_lockout !== 1'b1) begin
      errors++;
      $display("FAIL key_in_lockout: act=%b lo=%b, required act=0 lo=1", dbg_active, dbg_lockout);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (dbg_lockout !== 1'b0 || lock_status !== 3'b000) begin
      errors++;
      $display("FAIL reset_clears_lockout: lo=%b lock=%b, required lo=0 lock=000", dbg_lockout, lock_status);
    end
    @(negedge Clk);
    resetn = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_write();
    logic rv, re;
    do_write(2'd0, 16'hABCD, '0, rv, re);
    checks++;
    if (re !== 1'b0 || Data_out[0 +: WIDTH] !== 16'hABCD) begin
      errors++;
      $display("FAIL write_after_reset: re=%b ch0=%h, required re=0 ch0=ABCD", re, Data_out[0 +: WIDTH]);
    end
    @(negedge Clk);
    wr_valid = 1'b1; wr_ch = 2'd1; wr_data = 16'h7777;
    @(posedge Clk);
    #2;
    resetn = 1'b0; wr_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (resp_valid !== 1'b0 || Data_out !== '0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: rv=%b data=%h rdy=%b, required rv=0 data=0 rdy=0",
               resp_valid, Data_out, wr_ready);
    end
    @(negedge Clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_late_resp: rv=%b, required 0", resp_valid);
    end
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_lock();
    test_debug();
    test_timeout();
    test_lockout();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
